// File: rtl/alu_ctrl_issue_if.sv
// Issue-stage bundle: decode-side request, flush, and registered EX operands.
// The slave modport is the issue stage; master is whoever drives decode and consumes EX.
interface alu_ctrl_issue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             alu_src;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [3:0]       alu_control;
    logic             branch_inv;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport slave (
        input  in_valid, alu_op, funct3, funct7_5, alu_src, rs1_data, rs2_data, imm,
        input  flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_control, branch_inv, illegal,
        output illegal_cnt
    );

    modport master (
        output in_valid, alu_op, funct3, funct7_5, alu_src, rs1_data, rs2_data, imm,
        output flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_control, branch_inv, illegal,
        input  illegal_cnt
    );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ID/EX issue stage: decodes ALUOp/funct fields to the 4-bit ALU control code, picks
// operand B and holds everything in a single-entry register with valid/ready and flush.
module alu_ctrl_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    alu_ctrl_issue_if.slave bus
);
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluXor = 4'b0011;
    localparam logic [3:0] AluSll = 4'b0100;
    localparam logic [3:0] AluSrl = 4'b0101;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSra = 4'b0111;
    localparam logic [3:0] AluIll = 4'b1111;

    logic             valid_q;
    logic [XLEN-1:0]  a_q, b_q;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             inv_q, inv_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready;
    logic             accept;

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        ctrl_d = AluAdd;
        inv_d  = 1'b0;
        ill_d  = 1'b0;
        case (bus.alu_op)
            2'b00: ctrl_d = AluAdd;
            2'b01: begin
                case (bus.funct3)
                    3'b000: ctrl_d = AluSub;
                    3'b001: begin
                        ctrl_d = AluSub;
                        inv_d  = 1'b1;
                    end
                    default: begin
                        ctrl_d = AluIll;
                        ill_d  = 1'b1;
                    end
                endcase
            end
            default: begin
                case (bus.funct3)
                    // Only R-type uses funct7_5 to pick SUB; for I-type it is imm bit 10.
                    3'b000: ctrl_d = (bus.alu_op == 2'b10 && bus.funct7_5) ? AluSub : AluAdd;
                    3'b001: ctrl_d = AluSll;
                    3'b100: ctrl_d = AluXor;
                    3'b101: ctrl_d = bus.funct7_5 ? AluSra : AluSrl;
                    3'b110: ctrl_d = AluOr;
                    3'b111: ctrl_d = AluAnd;
                    default: begin
                        ctrl_d = AluIll;
                        ill_d  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= AluAnd;
            inv_q   <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                a_q    <= bus.rs1_data;
                b_q    <= bus.alu_src ? bus.imm : bus.rs2_data;
                ctrl_q <= ctrl_d;
                inv_q  <= inv_d;
                ill_q  <= ill_d;
                if (ill_d && cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_control = ctrl_q;
    assign bus.branch_inv  = inv_q;
    assign bus.illegal     = ill_q;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue: decode table, back-pressure, flush and counter saturation.
module tb_alu_ctrl_issue;
    localparam int unsigned XLEN  = 32;
    // Narrow counter so saturation is reachable in a few cycles.
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_ctrl_issue_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    alu_ctrl_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  ctrl;
        logic        inv;
        logic        ill;
    } vec_t;

    vec_t vecs[16];
    int   nchecks = 0;
    int   nerrs   = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.alu_op   = v.op;
        bus.funct3   = v.f3;
        bus.funct7_5 = v.f7;
        bus.alu_src  = v.src;
        bus.rs1_data = v.rs1;
        bus.rs2_data = v.rs2;
        bus.imm      = v.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //        op     f3      f7    src   rs1          rs2          imm          ctrl     inv   ill
        vecs[0]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'h10,      32'h3,       32'h0,       4'b0110, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 3'b101, 1'b1, 1'b1, 32'h1234,    32'h9,       32'h404,     4'b0111, 1'b0, 1'b0};
        vecs[2]  = '{2'b11, 3'b000, 1'b1, 1'b1, 32'h55,      32'h9,       32'h404,     4'b0010, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 3'b001, 1'b0, 1'b0, 32'h7,       32'h5,       32'hFFF,     4'b0110, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 3'b100, 1'b0, 1'b0, 32'h8,       32'h6,       32'h0,       4'b1111, 1'b0, 1'b1};
        vecs[5]  = '{2'b01, 3'b000, 1'b1, 1'b0, 32'h9,       32'h9,       32'h0,       4'b0110, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 3'b010, 1'b0, 1'b1, 32'h1000,    32'hDEAD,    32'hFFFFFFFC, 4'b0010, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 3'b001, 1'b0, 1'b0, 32'h1,       32'h21,      32'h0,       4'b0100, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0,    32'h0FF0,    32'h0,       4'b0011, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 3'b101, 1'b0, 1'b0, 32'h80000000, 32'h4,      32'h0,       4'b0101, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 3'b110, 1'b1, 1'b0, 32'hA,       32'h5,       32'h0,       4'b0001, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 3'b111, 1'b0, 1'b1, 32'hFF,      32'h1,       32'h0F,      4'b0000, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 3'b010, 1'b0, 1'b0, 32'h3,       32'h4,       32'h0,       4'b1111, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 3'b011, 1'b0, 1'b1, 32'h3,       32'h4,       32'h77,      4'b1111, 1'b0, 1'b1};
        vecs[14] = '{2'b10, 3'b000, 1'b0, 1'b0, 32'h20,      32'h2,       32'h0,       4'b0010, 1'b0, 1'b0};
        vecs[15] = '{2'b11, 3'b101, 1'b0, 1'b1, 32'hC0,      32'h0,       32'h3,       4'b0101, 1'b0, 1'b0};

        // Reset held two cycles with a request present.
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        drive(vecs[4]);
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_alu_control", 64'(bus.alu_control), 64'd0);
        chk("rst_illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
        chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Decode table, back-to-back with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            drive(v);
            bus.in_valid = 1'b1;
            tick();
            if (v.ill && exp_cnt < int'(CNT_MAX)) exp_cnt++;
            chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("v%0d_ctrl", i), 64'(bus.alu_control), 64'(v.ctrl));
            chk($sformatf("v%0d_a", i), 64'(bus.alu_a), 64'(v.rs1));
            chk($sformatf("v%0d_b", i), 64'(bus.alu_b), 64'(v.src ? v.imm : v.rs2));
            chk($sformatf("v%0d_inv", i), 64'(bus.branch_inv), 64'(v.inv));
            chk($sformatf("v%0d_ill", i), 64'(bus.illegal), 64'(v.ill));
            chk($sformatf("v%0d_cnt", i), 64'(bus.illegal_cnt), 64'(exp_cnt));
        end

        // Back-pressure: held op is vecs[15]; new XOR op waits.
        bus.out_ready = 1'b0;
        v = '{2'b10, 3'b100, 1'b0, 1'b0, 32'hAA, 32'hBB, 32'h0, 4'b0011, 1'b0, 1'b0};
        drive(v);
        #1;
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d_ctrl", i), 64'(bus.alu_control), 64'(4'b0101));
            chk($sformatf("bp%0d_a", i), 64'(bus.alu_a), 64'hC0);
            chk($sformatf("bp%0d_b", i), 64'(bus.alu_b), 64'h3);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_new_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_new_ctrl", 64'(bus.alu_control), 64'(4'b0011));
        chk("bp_new_a", 64'(bus.alu_a), 64'hAA);
        chk("bp_new_b", 64'(bus.alu_b), 64'hBB);

        // Drain: valid drops, data holds.
        bus.in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_a_hold", 64'(bus.alu_a), 64'hAA);

        // Flush with a held op and an illegal request under back-pressure.
        bus.in_valid = 1'b1;
        drive(vecs[7]);
        tick();
        chk("fl_load_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        drive(vecs[12]);
        tick();
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_cnt", 64'(bus.illegal_cnt), 64'(exp_cnt));
        chk("fl_ctrl_hold", 64'(bus.alu_control), 64'(4'b0100));
        chk("fl_illegal", 64'(bus.illegal), 64'd0);
        // Flush with an idle stage and ready consumer also drops the request.
        bus.out_ready = 1'b1;
        #1;
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("fl2_valid", 64'(bus.out_valid), 64'd0);
        chk("fl2_cnt", 64'(bus.illegal_cnt), 64'(exp_cnt));
        bus.flush = 1'b0;

        // Saturation: stream illegal ops past the counter ceiling.
        drive(vecs[13]);
        for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
            tick();
            if (exp_cnt < int'(CNT_MAX)) exp_cnt++;
            chk($sformatf("sat%0d_cnt", i), 64'(bus.illegal_cnt), 64'(exp_cnt));
        end
        chk("sat_final", 64'(bus.illegal_cnt), 64'(CNT_MAX));

        // Reset clears the counter.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_cnt", 64'(bus.illegal_cnt), 64'd0);
        chk("rst2_valid", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- ID/EX issue stage that sits in front of the EX-stage ALU.
- Decodes ALUOp/funct3/funct7 into the team's 4-bit ALUcontrol encoding and selects operand B (register or immediate).
- Registers the A, B and control operands into a single-entry pipeline register with a valid/ready handshake, stall back-pressure and flush.
- Tags branch polarity so the branch unit can interpret the ALU zeroflag.

Parameters:
- XLEN, 32, operand width.
- CNT_W, 16, width of the saturating illegal-op counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction bits [14:12].
- funct7_5  in  1  instruction bit 30.
- alu_src  in  1  1 selects imm for B, 0 selects rs2_data.
- rs1_data  in  XLEN  operand A source.
- rs2_data  in  XLEN  register operand B source.
- imm  in  XLEN  sign-extended immediate.
- flush  in  1  kill the held and the incoming instruction.
- out_valid  out  1  EX operands valid.
- out_ready  in  1  EX stage consumes this cycle.
- alu_a  out  XLEN  registered operand A.
- alu_b  out  XLEN  registered operand B.
- alu_control  out  4  registered ALU operation code.
- branch_inv  out  1  1 means branch taken when zeroflag==0 (BNE).
- illegal  out  1  registered: the held op is unsupported.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal ops.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, alu_a=0, alu_b=0, alu_control=4'b0000, branch_inv=0, illegal=0, illegal_cnt=0. Reset overrides flush and all handshakes.
- in_ready = !out_valid || out_ready. This is combinational and independent of flush.
- Accept = in_valid && in_ready && !flush. On accept, all outputs load next edge and out_valid=1. Latency is 1 cycle.
- If out_valid && !out_ready, all outputs hold stable. Inputs are not sampled.
- If out_valid && out_ready && !accept, out_valid clears next edge. Data regs hold their last value.
- If flush=1, out_valid=0 next edge regardless of in_valid/out_ready. An incoming op is dropped and illegal_cnt is not incremented.
- alu_b = alu_src ? imm : rs2_data. alu_a = rs1_data.
- Control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, ILLEGAL 1111.
- alu_op=00: ADD.
- alu_op=01:
  - funct3 000 (BEQ) gives SUB, branch_inv=0.
  - funct3 001 (BNE) gives SUB, branch_inv=1.
  - All other funct3 values are illegal.
- alu_op=10/11 by funct3:
  - 000: R-type with funct7_5=1 gives SUB, otherwise ADD. I-type always gives ADD; funct7_5 is ignored.
  - 001: SLL.
  - 100: XOR.
  - 101: SRA if funct7_5 else SRL, for both R-type and I-type.
  - 110: OR.
  - 111: AND.
  - 010 and 011 (SLT/SLTU) are unsupported and illegal.
- Illegal op: alu_control=1111, illegal=1, branch_inv=0. The op still issues with out_valid=1; the downstream trap logic owns handling.
- branch_inv=0 for every alu_op other than 01.
- illegal_cnt increments by 1 on each accepted illegal op and saturates at all-ones. It is cleared only by reset.
- Shift amount masking is owned by the ALU. This block passes alu_b unmodified.

Test Plan:
- Reset held 2 cycles with in_valid=1 -> out_valid=0, alu_control=0000, illegal_cnt=0, in_ready=1 after release.
- R-type funct3=000 funct7_5=1, rs1=0x10, rs2=0x3, alu_src=0, out_ready=1 -> next cycle out_valid=1, alu_control=0110, alu_a=0x10, alu_b=0x3.
- I-type funct3=101 funct7_5=1, imm=0x404, alu_src=1 -> alu_control=0111, alu_b=0x404. Repeat with funct3=000 funct7_5=1 -> 0010 (ADD, not SUB).
- BNE (alu_op=01, funct3=001) -> alu_control=0110, branch_inv=1. funct3=100 (BLT) -> alu_control=1111, illegal=1, illegal_cnt=1.
- Back-pressure: out_ready=0 for 3 cycles with a new op presented -> in_ready=0 and outputs unchanged. Then out_ready=1 -> held op retires and the new op loads on the next edge.
- flush=1 with out_valid=1 and an illegal in_valid op -> out_valid=0 next cycle and illegal_cnt unchanged.
